// File: rtl/search_arbiter.sv
// Arbitrates between four key-search cores: launches them, latches the first
// (lowest-index) winner or reports exhaustion, and times the search.
module search_arbiter (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        go,
    input  logic [3:0]  solution_core,
    input  logic [3:0]  exhausted_core,
    input  logic [23:0] core_key0,
    input  logic [23:0] core_key1,
    input  logic [23:0] core_key2,
    input  logic [23:0] core_key3,
    output logic        start_cores,
    output logic        stop,
    output logic        found,
    output logic        no_key,
    output logic [1:0]  winner_id,
    output logic [23:0] winning_key,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {IDLE, LAUNCH, SEARCH, FOUND, NO_KEY} state_t;

    state_t      state_q, state_d;
    logic        go_q;
    logic        armed_q, armed_d;
    logic        start_cores_q, start_cores_d;
    logic        stop_q, stop_d;
    logic        found_q, found_d;
    logic        no_key_q, no_key_d;
    logic [1:0]  winner_id_q, winner_id_d;
    logic [23:0] winning_key_q, winning_key_d;
    logic [31:0] cycle_count_q, cycle_count_d;

    logic [23:0] keys [4];
    logic        go_edge;
    logic        hit;
    logic [1:0]  sel_id;
    logic [23:0] sel_key;

    always_comb begin
        keys[0] = core_key0;
        keys[1] = core_key1;
        keys[2] = core_key2;
        keys[3] = core_key3;
    end

    // armed_q blocks an edge until go has been seen low since reset, so a go
    // already high at reset release is not mistaken for a request.
    assign go_edge = go && !go_q && armed_q;
    assign armed_d = armed_q || !go;

    // Fixed priority: lowest index wins.
    always_comb begin
        hit     = 1'b0;
        sel_id  = '0;
        sel_key = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!hit && solution_core[i]) begin
                hit     = 1'b1;
                sel_id  = i[1:0];
                sel_key = keys[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        start_cores_d = 1'b0;
        stop_d        = stop_q;
        found_d       = found_q;
        no_key_d      = no_key_q;
        winner_id_d   = winner_id_q;
        winning_key_d = winning_key_q;
        cycle_count_d = cycle_count_q;

        case (state_q)
            IDLE, FOUND, NO_KEY: begin
                if (go_edge) begin
                    state_d       = LAUNCH;
                    start_cores_d = 1'b1;
                    stop_d        = 1'b0;
                    found_d       = 1'b0;
                    no_key_d      = 1'b0;
                    winner_id_d   = '0;
                    winning_key_d = '0;
                    cycle_count_d = '0;
                end
            end
            LAUNCH: begin
                state_d = SEARCH;
            end
            SEARCH: begin
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 32'd1;
                end
                if (hit) begin
                    state_d       = FOUND;
                    stop_d        = 1'b1;
                    found_d       = 1'b1;
                    winner_id_d   = sel_id;
                    winning_key_d = sel_key;
                end else if (&exhausted_core) begin
                    state_d  = NO_KEY;
                    stop_d   = 1'b1;
                    no_key_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            go_q          <= 1'b0;
            armed_q       <= !go;
            start_cores_q <= 1'b0;
            stop_q        <= 1'b0;
            found_q       <= 1'b0;
            no_key_q      <= 1'b0;
            winner_id_q   <= '0;
            winning_key_q <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            go_q          <= go;
            armed_q       <= armed_d;
            start_cores_q <= start_cores_d;
            stop_q        <= stop_d;
            found_q       <= found_d;
            no_key_q      <= no_key_d;
            winner_id_q   <= winner_id_d;
            winning_key_q <= winning_key_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign start_cores = start_cores_q;
    assign stop        = stop_q;
    assign found       = found_q;
    assign no_key      = no_key_q;
    assign winner_id   = winner_id_q;
    assign winning_key = winning_key_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_search_arbiter.sv
// Scoreboard bench for search_arbiter: stimulus queues expected search results,
// a monitor checks them when stop rises.
module tb_search_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go;
    logic [3:0]  sol;
    logic [3:0]  exh;
    logic [23:0] key0, key1, key2, key3;
    logic        start_cores, stop, found, no_key;
    logic [1:0]  winner_id;
    logic [23:0] winning_key;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    typedef struct {
        logic        f;
        logic        nk;
        logic [1:0]  id;
        logic [23:0] key;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    always #10 clk = ~clk;

    search_arbiter dut (
        .CLOCK_50       (clk),
        .reset_n        (reset_n),
        .go             (go),
        .solution_core  (sol),
        .exhausted_core (exh),
        .core_key0      (key0),
        .core_key1      (key1),
        .core_key2      (key2),
        .core_key3      (key3),
        .start_cores    (start_cores),
        .stop           (stop),
        .found          (found),
        .no_key         (no_key),
        .winner_id      (winner_id),
        .winning_key    (winning_key),
        .cycle_count    (cycle_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic f, input logic nk, input logic [1:0] id,
                        input logic [23:0] key, input logic [31:0] cnt);
        exp_t e;
        e.f = f; e.nk = nk; e.id = id; e.key = key; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(start_cores), 0);
        chk({tag, "_stop"},  32'(stop), 0);
        chk({tag, "_found"}, 32'(found), 0);
        chk({tag, "_nokey"}, 32'(no_key), 0);
        chk({tag, "_id"},    32'(winner_id), 0);
        chk({tag, "_key"},   32'(winning_key), 0);
        chk({tag, "_count"}, cycle_count, 0);
    endtask

    // Raise go, wait for the launch pulse, confirm the cleared outputs, drop go.
    task automatic launch(input string tag);
        bit seen = 0;
        go = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (start_cores) seen = 1;
        end
        chk({tag, "_start_seen"}, 32'(seen), 1);
        chk({tag, "_launch_stop"},  32'(stop), 0);
        chk({tag, "_launch_found"}, 32'(found), 0);
        chk({tag, "_launch_nokey"}, 32'(no_key), 0);
        chk({tag, "_launch_key"},   32'(winning_key), 0);
        chk({tag, "_launch_count"}, cycle_count, 0);
        go = 1'b0;
    endtask

    task automatic wait_stop(input string tag);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (stop) seen = 1;
        end
        chk({tag, "_stop_seen"}, 32'(seen), 1);
    endtask

    // Monitor: every rising stop is one search result.
    initial begin
        logic stop_prev = 1'b0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (stop && !stop_prev) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got stop=1, expected no result pending");
                end else begin
                    e = sb.pop_front();
                    chk("res_found",  32'(found), 32'(e.f));
                    chk("res_nokey",  32'(no_key), 32'(e.nk));
                    chk("res_id",     32'(winner_id), 32'(e.id));
                    chk("res_key",    32'(winning_key), 32'(e.key));
                    chk("res_count",  cycle_count, e.cnt);
                    chk("res_start",  32'(start_cores), 0);
                end
            end
            stop_prev = stop;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (start_cores) pulses++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        reset_n = 1'b0; go = 1'b0; sol = '0; exh = '0;
        key0 = '0; key1 = '0; key2 = '0; key3 = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Basic find by core 2 after 50 search cycles, then frozen
        push(1'b1, 1'b0, 2'd2, 24'h301A2B, 32'd50);
        launch("t1");
        repeat (50) @(negedge clk);
        key2 = 24'h301A2B; sol = 4'b0100;
        wait_stop("t1");
        sol = '0; key2 = 24'h111111; exh = 4'b1111;
        repeat (5) @(negedge clk);
        chk("frz_found", 32'(found), 1);
        chk("frz_nokey", 32'(no_key), 0);
        chk("frz_stop",  32'(stop), 1);
        chk("frz_id",    32'(winner_id), 2);
        chk("frz_key",   32'(winning_key), 32'h301A2B);
        chk("frz_count", cycle_count, 50);
        exh = '0;

        // Simultaneous find: lowest index wins (restart from FOUND)
        push(1'b1, 1'b0, 2'd1, 24'h000055, 32'd5);
        launch("t2");
        repeat (5) @(negedge clk);
        key1 = 24'h000055; key3 = 24'h3FFFFF; sol = 4'b1010;
        wait_stop("t2");
        sol = '0;

        // Gradual exhaustion: only the full set stops the search
        launch("t3");
        repeat (3) @(negedge clk);
        exh = 4'b0001; @(negedge clk);
        chk("exh1_stop", 32'(stop), 0);
        exh = 4'b0011; @(negedge clk);
        chk("exh2_stop", 32'(stop), 0);
        exh = 4'b0111; @(negedge clk);
        chk("exh3_stop",  32'(stop), 0);
        chk("exh3_nokey", 32'(no_key), 0);
        push(1'b0, 1'b1, 2'd0, 24'h0, 32'd6);
        exh = 4'b1111;
        wait_stop("t3");
        exh = '0;

        // Solution beats exhaustion in the same cycle (restart from NO_KEY)
        push(1'b1, 1'b0, 2'd0, 24'h0ABCDE, 32'd2);
        launch("t4");
        repeat (2) @(negedge clk);
        key0 = 24'h0ABCDE; sol = 4'b0001; exh = 4'b1111;
        wait_stop("t4");
        sol = '0; exh = '0;

        // go held high: a single launch pulse; toggling go in SEARCH is ignored
        p0 = pulses;
        go = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_pulses", 32'(pulses - p0), 1);
        chk("hold_count",  cycle_count, 8);
        go = 1'b0; @(negedge clk);
        go = 1'b1; @(negedge clk);
        go = 1'b0; @(negedge clk);
        chk("tog_pulses", 32'(pulses - p0), 1);
        chk("tog_stop",   32'(stop), 0);
        chk("tog_found",  32'(found), 0);
        chk("tog_count",  cycle_count, 11);
        repeat (89) @(negedge clk);
        chk("pre_rst_count", cycle_count, 100);

        // Reset mid-SEARCH, released with go already high
        reset_n = 1'b0;
        @(negedge clk);
        chk_all_zero("midrst");
        go = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        p0 = pulses;
        repeat (5) @(negedge clk);
        chk("gohigh_pulses", 32'(pulses - p0), 0);
        chk("gohigh_stop",   32'(stop), 0);
        go = 1'b0;
        @(negedge clk);
        push(1'b1, 1'b0, 2'd3, 24'h123456, 32'd3);
        launch("t6");
        repeat (3) @(negedge clk);
        key3 = 24'h123456; sol = 4'b1000;
        wait_stop("t6");
        sol = '0;

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
